gen_scheduler: RTL and testbench
================================

Name: gen_scheduler

Overview:
Top-level sequencer for the double-buffered Game of Life datapath.
- Decides when a config load or a generation step runs. Loads take priority over steps.
- Paces generation steps by counting VGA frames.
- Owns the front/back field selection. Both the loader and the iterator write only the back field.
- Swaps front and back only at a frame boundary, so the display never shows a half-written field.
- Sits between the button filters, vga, next_field_iter and field_cfg_loader. Replaces their standalone go/pause controllers.

Parameters:
SPEED_W, 4, width of i_speed (frames per generation).
GEN_W, 16, width of the generation counter.

Ports:
clk  in  1  system clock (VGA pixel clock)
rst_n  in  1  asynchronous active-low reset
i_cmd_toggle_pause  in  1  single-cycle pulse, toggles run/pause
i_cmd_load_cfg_1  in  1  single-cycle pulse, request load of config 1
i_cmd_load_cfg_2  in  1  single-cycle pulse, request load of config 2
i_frame_start  in  1  single-cycle pulse from vga at start of vertical blank
i_speed  in  SPEED_W  frames per generation; 0 treated as 1
i_nfi_busy  in  1  next_field_iter simulating
i_fcl_busy  in  1  field_cfg_loader loading
o_nfi_go  out  1  start request to next_field_iter (level, see handshake)
o_fcl_go  out  1  start request to field_cfg_loader (level)
o_fcl_cfg  out  cfg_req_t  config being loaded; NO_REQ when no load active
o_front_field  out  field_t  field read by VGA and by the iterator; back field = the other one
o_paused  out  1  run/pause state
o_gen_count  out  GEN_W  generations completed since last load

Behaviour:
Reset values:
- State IDLE, o_paused=1, o_front_field=FIELD_A, o_fcl_cfg=NO_REQ, o_gen_count=0.
- Both go outputs 0, pending=NO_REQ, frame counter 0.

Pause:
- i_cmd_toggle_pause flips o_paused next cycle, in any state.
- A running step or load always completes; pause only gates starting the next step.

Load request latch (pending):
- cfg_1 and cfg_2 pulses in the same cycle: CFG_1 wins.
- A later request overwrites an earlier pending one.
- Requests arriving during any state are kept.

Frame counter (SPEED_W bits):
- Increments on i_frame_start while not paused; saturates at all-ones.
- Held at 0 while paused.
- Cleared on entry to SIM_START. A simultaneous frame pulse is lost.

FSM (registered, one transition per cycle):
- IDLE:
  - pending!=NO_REQ -> LOAD_START; pending is copied to o_fcl_cfg and cleared. Loads are allowed while paused.
  - else if !paused and count >= max(i_speed,1) -> SIM_START.
- LOAD_START: o_fcl_go=1 until i_fcl_busy=1, then -> LOAD_RUN.
- LOAD_RUN: wait i_fcl_busy=0 -> SWAP_WAIT (kind=LOAD).
- SIM_START: o_nfi_go=1 until i_nfi_busy=1, then -> SIM_RUN.
- SIM_RUN: wait i_nfi_busy=0 -> SWAP_WAIT (kind=SIM).
- SWAP_WAIT: on i_frame_start, o_front_field toggles next cycle, then -> IDLE.
  - kind=SIM: o_gen_count+1, wraps to 0.
  - kind=LOAD: o_gen_count=0 and o_fcl_cfg returns to NO_REQ.
- Go outputs are combinational from state: high only in their START state, never both high.

Latency and boundaries:
- Go deasserts the cycle after busy is sampled high.
- A step or load never starts outside IDLE, so the iterator and loader never overlap.
- A load requested mid-SIM runs after that step's swap.
- A frame pulse arriving on the same cycle busy falls is not the swap pulse; the swap waits for the next frame.
- Asynchronous reset mid-operation returns all registers to reset values immediately. The children are reset by the same rst_n.

Decomposition:
- Package defs_gol holds:
  - field_t {FIELD_A, FIELD_B} and cfg_req_t {NO_REQ, CFG_1, CFG_2}, shared with top, next_field_iter and field_cfg_loader.
  - sched_state_t {IDLE, LOAD_START, LOAD_RUN, SIM_START, SIM_RUN, SWAP_WAIT}.
- Sub-module frame_pacer: saturating frame counter with clear and enable. It outputs o_due = count >= max(i_speed,1).

Test Plan:
- Reset, no stimulus for 5 frames -> o_paused=1, no go, o_front_field=FIELD_A, o_gen_count=0.
- Pulse load_cfg_2 while paused; busy model 10 cycles -> o_fcl_go until busy, o_fcl_cfg=CFG_2. o_front_field becomes FIELD_B the cycle after the next frame_start; then o_fcl_cfg=NO_REQ.
- Unpause, i_speed=3, NFI model 20 cycles -> o_nfi_go once per 3 frame_starts. Front toggles each step; o_gen_count goes 1, 2, 3.
- load_cfg_1 and load_cfg_2 pulsed in the same cycle during SIM_RUN -> step completes and swaps (gen+1). Then CFG_1 loads, and after its swap o_gen_count=0.
- Pause toggled during SIM_RUN -> step finishes and swaps. No further o_nfi_go for 10 frames; frame counter stays 0.
- rst_n low during LOAD_RUN -> all outputs at reset values asynchronously; pending load discarded.

Source files
------------

// File: rtl/defs_gol.sv
// Types shared by the Game of Life sequencer, next_field_iter and field_cfg_loader.
package defs_gol;

   typedef enum logic {FIELD_A, FIELD_B} field_t;

   typedef enum logic [1:0] {NO_REQ, CFG_1, CFG_2} cfg_req_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_START,
      LOAD_RUN,
      SIM_START,
      SIM_RUN,
      SWAP_WAIT
   } sched_state_t;

   // What the pending swap finishes; selects generation count update.
   typedef enum logic {KIND_LOAD, KIND_SIM} swap_kind_t;

endpackage

// File: rtl/frame_pacer.sv
// Saturating frame counter; flags when enough frames have passed for the next generation.
module frame_pacer #(
   parameter int unsigned SPEED_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clear,
   input  logic               i_enable,
   input  logic [SPEED_W-1:0] i_speed,
   output logic               o_due
);

   logic [SPEED_W-1:0] count_q;
   logic [SPEED_W-1:0] speed_eff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (i_clear) begin
         count_q <= '0;
      end else if (i_enable && (count_q != {SPEED_W{1'b1}})) begin
         count_q <= count_q + SPEED_W'(1);
      end
   end

   // A speed of 0 behaves like 1 so the pacer can never stall forever.
   assign speed_eff = (i_speed == '0) ? SPEED_W'(1) : i_speed;
   assign o_due     = (count_q >= speed_eff);

endmodule

// File: rtl/gen_scheduler.sv
// Sequencer for the double-buffered Game of Life datapath: orders loads and steps,
// paces steps by frames and flips front/back fields only on frame boundaries.
module gen_scheduler
   import defs_gol::*;
#(
   parameter int unsigned SPEED_W = 4,
   parameter int unsigned GEN_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_cmd_toggle_pause,
   input  logic               i_cmd_load_cfg_1,
   input  logic               i_cmd_load_cfg_2,
   input  logic               i_frame_start,
   input  logic [SPEED_W-1:0] i_speed,
   input  logic               i_nfi_busy,
   input  logic               i_fcl_busy,
   output logic               o_nfi_go,
   output logic               o_fcl_go,
   output cfg_req_t           o_fcl_cfg,
   output field_t             o_front_field,
   output logic               o_paused,
   output logic [GEN_W-1:0]   o_gen_count
);

   sched_state_t     state_q, state_d;
   swap_kind_t       kind_q, kind_d;
   cfg_req_t         pending_q, pending_d;
   cfg_req_t         cfg_q, cfg_d;
   field_t           front_q, front_d;
   logic [GEN_W-1:0] gen_q, gen_d;
   logic             paused_q;
   logic             sim_entry;
   logic             due;

   frame_pacer #(
      .SPEED_W (SPEED_W)
   ) u_frame_pacer (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_clear  (paused_q | sim_entry),
      .i_enable (i_frame_start),
      .i_speed  (i_speed),
      .o_due    (due)
   );

   always_comb begin
      state_d   = state_q;
      kind_d    = kind_q;
      pending_d = pending_q;
      cfg_d     = cfg_q;
      front_d   = front_q;
      gen_d     = gen_q;
      sim_entry = 1'b0;
      case (state_q)
         IDLE: begin
            if (pending_q != NO_REQ) begin
               state_d   = LOAD_START;
               cfg_d     = pending_q;
               pending_d = NO_REQ;
            end else if (!paused_q && due) begin
               state_d   = SIM_START;
               sim_entry = 1'b1;
            end
         end
         LOAD_START: if (i_fcl_busy) state_d = LOAD_RUN;
         LOAD_RUN: begin
            if (!i_fcl_busy) begin
               state_d = SWAP_WAIT;
               kind_d  = KIND_LOAD;
            end
         end
         SIM_START: if (i_nfi_busy) state_d = SIM_RUN;
         SIM_RUN: begin
            if (!i_nfi_busy) begin
               state_d = SWAP_WAIT;
               kind_d  = KIND_SIM;
            end
         end
         SWAP_WAIT: begin
            if (i_frame_start) begin
               state_d = IDLE;
               front_d = (front_q == FIELD_A) ? FIELD_B : FIELD_A;
               if (kind_q == KIND_SIM) begin
                  gen_d = gen_q + GEN_W'(1);
               end else begin
                  gen_d = '0;
                  cfg_d = NO_REQ;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      // Fresh requests override whatever was pending or just consumed.
      if (i_cmd_load_cfg_1) begin
         pending_d = CFG_1;
      end else if (i_cmd_load_cfg_2) begin
         pending_d = CFG_2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         kind_q    <= KIND_LOAD;
         pending_q <= NO_REQ;
         cfg_q     <= NO_REQ;
         front_q   <= FIELD_A;
         gen_q     <= '0;
         paused_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         kind_q    <= kind_d;
         pending_q <= pending_d;
         cfg_q     <= cfg_d;
         front_q   <= front_d;
         gen_q     <= gen_d;
         paused_q  <= paused_q ^ i_cmd_toggle_pause;
      end
   end

   assign o_fcl_go      = (state_q == LOAD_START);
   assign o_nfi_go      = (state_q == SIM_START);
   assign o_fcl_cfg     = cfg_q;
   assign o_front_field = front_q;
   assign o_paused      = paused_q;
   assign o_gen_count   = gen_q;

endmodule

// File: tb/tb_gen_scheduler.sv
// Randomized bench for gen_scheduler against a job-level reference model.
module tb_gen_scheduler;
   import defs_gol::*;

   localparam int SPEED_W = 4;
   localparam int GEN_W   = 16;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               cmd_toggle, cmd_cfg_1, cmd_cfg_2, frame_start;
   logic [SPEED_W-1:0] speed;
   logic               nfi_busy, fcl_busy;
   logic               nfi_go, fcl_go, paused;
   cfg_req_t           fcl_cfg;
   field_t             front_field;
   logic [GEN_W-1:0]   gen_count;

   gen_scheduler #(
      .SPEED_W (SPEED_W),
      .GEN_W   (GEN_W)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .i_cmd_toggle_pause (cmd_toggle),
      .i_cmd_load_cfg_1   (cmd_cfg_1),
      .i_cmd_load_cfg_2   (cmd_cfg_2),
      .i_frame_start      (frame_start),
      .i_speed            (speed),
      .i_nfi_busy         (nfi_busy),
      .i_fcl_busy         (fcl_busy),
      .o_nfi_go           (nfi_go),
      .o_fcl_go           (fcl_go),
      .o_fcl_cfg          (fcl_cfg),
      .o_front_field      (front_field),
      .o_paused           (paused),
      .o_gen_count        (gen_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      if (obs != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: job 0 none / 1 load / 2 step; started = child reported busy; swap = awaiting frame.
   int m_job, m_pend, m_cfg, m_front, m_gen, m_cnt;
   bit m_started, m_swap, m_paused;

   function automatic void model_reset();
      m_job = 0; m_pend = 0; m_cfg = 0; m_front = 0; m_gen = 0; m_cnt = 0;
      m_started = 0; m_swap = 0; m_paused = 1;
   endfunction

   function automatic bit m_fcl_go();
      return m_job == 1 && !m_started && !m_swap;
   endfunction

   function automatic bit m_nfi_go();
      return m_job == 2 && !m_started && !m_swap;
   endfunction

   function automatic void model_step(bit fr, bit c1, bit c2, bit tg, int spd, bit fb, bit nb);
      int np, nc, eff;
      bit busy;
      eff  = (spd == 0) ? 1 : spd;
      np   = c1 ? 1 : (c2 ? 2 : m_pend);
      nc   = m_paused ? 0 : (fr ? ((m_cnt < 15) ? m_cnt + 1 : 15) : m_cnt);
      busy = (m_job == 1) ? fb : nb;
      if (m_job == 0) begin
         if (m_pend != 0) begin
            m_job = 1; m_started = 0; m_cfg = m_pend;
            if (!c1 && !c2) np = 0;
         end else if (!m_paused && m_cnt >= eff) begin
            m_job = 2; m_started = 0; nc = 0;
         end
      end else if (m_swap) begin
         if (fr) begin
            m_front ^= 1;
            if (m_job == 2) m_gen = (m_gen + 1) & 'hFFFF;
            else begin
               m_gen = 0; m_cfg = 0;
            end
            m_job = 0; m_swap = 0; m_started = 0;
         end
      end else if (!m_started) begin
         if (busy) m_started = 1;
      end else if (!busy) begin
         m_swap = 1;
      end
      m_pend = np; m_cnt = nc; m_paused ^= tg;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_fcl_go"}, int'(fcl_go), int'(m_fcl_go()));
      check({tag, "_nfi_go"}, int'(nfi_go), int'(m_nfi_go()));
      check({tag, "_cfg"}, int'(fcl_cfg), m_cfg);
      check({tag, "_front"}, int'(front_field), m_front);
      check({tag, "_paused"}, int'(paused), int'(m_paused));
      check({tag, "_gen"}, int'(gen_count), m_gen);
   endtask

   // Stimulus state: frame generator and child busy responders.
   int fctr = 0, period = 16, spd = 3;
   bit rand_frames = 0;
   bit fb = 0, nb = 0;
   int f_len = 0, f_dly = 0, n_len = 0, n_dly = 0;

   task automatic cyc(input bit c1, input bit c2, input bit tg, input bit rs);
      bit fr;
      @(negedge clk);
      check_outputs("cyc");
      if (rs) begin
         rst_n = 1'b0;
         #1;
         model_reset();
         check_outputs("async_rst");
         fb = 0; nb = 0; f_dly = 0; n_dly = 0;
         fcl_busy = 0; nfi_busy = 0; cmd_cfg_1 = 0; cmd_cfg_2 = 0; cmd_toggle = 0;
         frame_start = 0;
         @(negedge clk);
         rst_n = 1'b1;
         check_outputs("post_rst");
      end
      fr = (fctr == 0);
      if (fctr == 0) begin
         if (rand_frames) period = $urandom_range(8, 24);
         fctr = period - 1;
      end else begin
         fctr--;
      end
      if (fb) begin
         if (f_len == 0) fb = 0; else f_len--;
      end else if (m_fcl_go()) begin
         if (f_dly == 0) begin
            fb = 1; f_len = $urandom_range(4, 10); f_dly = $urandom_range(0, 2);
         end else f_dly--;
      end
      if (nb) begin
         if (n_len == 0) nb = 0; else n_len--;
      end else if (m_nfi_go()) begin
         if (n_dly == 0) begin
            nb = 1; n_len = $urandom_range(5, 20); n_dly = $urandom_range(0, 2);
         end else n_dly--;
      end
      frame_start = fr; cmd_cfg_1 = c1; cmd_cfg_2 = c2; cmd_toggle = tg;
      speed = SPEED_W'(spd); fcl_busy = fb; nfi_busy = nb;
      model_step(fr, c1, c2, tg, spd, fb, nb);
   endtask

   initial begin
      int k;
      rst_n = 1'b0;
      cmd_toggle = 0; cmd_cfg_1 = 0; cmd_cfg_2 = 0; frame_start = 0;
      speed = SPEED_W'(3); nfi_busy = 0; fcl_busy = 0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle for five frames, then load config 2 while paused.
      repeat (5 * 16) cyc(0, 0, 0, 0);
      cyc(0, 1, 0, 0);
      repeat (60) cyc(0, 0, 0, 0);
      cyc(0, 0, 1, 0);
      repeat (400) cyc(0, 0, 0, 0);

      // Both loads in one cycle mid-step: step swaps first, then config 1 loads.
      for (k = 0; k < 500 && !(m_job == 2 && m_started && !m_swap); k++) cyc(0, 0, 0, 0);
      check("wait_sim_run_a", int'(k < 500), 1);
      cyc(1, 1, 0, 0);
      repeat (300) cyc(0, 0, 0, 0);

      // Pause mid-step: step finishes, then nothing starts for ten frames.
      for (k = 0; k < 500 && !(m_job == 2 && m_started && !m_swap); k++) cyc(0, 0, 0, 0);
      check("wait_sim_run_b", int'(k < 500), 1);
      cyc(0, 0, 1, 0);
      repeat (12 * 16) cyc(0, 0, 0, 0);

      // Reset while a load is running discards everything.
      cyc(0, 1, 0, 0);
      for (k = 0; k < 200 && !(m_job == 1 && m_started && !m_swap); k++) cyc(0, 0, 0, 0);
      check("wait_load_run", int'(k < 200), 1);
      cyc(0, 1, 0, 1);
      repeat (40) cyc(0, 0, 0, 0);

      // Randomized traffic.
      rand_frames = 1;
      for (int i = 0; i < 15000; i++) begin
         if ($urandom_range(0, 499) == 0) spd = $urandom_range(0, 5);
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 199) == 0,
             $urandom_range(0, 149) == 0, $urandom_range(0, 2999) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
